// File: rtl/mux_arb_2to1.sv
// Two-source arbiter feeding a single registered output word with source tag.
// MUX_ARB_ROUND_ROBIN_EN selects alternating contention; otherwise A has fixed priority.
module mux_arb_2to1 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_data;
    logic             r_src;
    logic             r_last_src;

    logic             w_can_load;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_accept;

    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
`ifdef MUX_ARB_ROUND_ROBIN_EN
        // under contention the source that did not win last time goes next
        w_grant_a = a_valid && (!b_valid || r_last_src);
`else
        w_grant_a = a_valid;
`endif
        w_grant_b = b_valid && !w_grant_a;
    end

    assign w_can_load = (r_state == EMPTY) || out_ready;
    assign a_ready    = rst_n && w_can_load && w_grant_a;
    assign b_ready    = rst_n && w_can_load && w_grant_b;
    assign w_accept   = a_ready || b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_data     <= '0;
            r_src      <= 1'b0;
            r_last_src <= 1'b1;
        end else begin
            if (w_accept) begin
                r_data     <= a_ready ? a_data : b_data;
                r_src      <= b_ready;
                r_last_src <= b_ready;
            end
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) r_state <= FULL;
                end
                FULL: begin
                    if (out_ready && !w_accept) r_state <= EMPTY;
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_mux_arb_2to1.sv
// Scoreboard bench for mux_arb_2to1: accepted words are queued and
// compared in order against words consumed downstream.
module tb_mux_arb_2to1;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] sb_q[$];

    mux_arb_2to1 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consume check first (word accepted at an earlier edge), then record new accept.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (a_ready && b_ready) begin
                errors++;
                $display("FAIL both_ready: a_ready=%0b b_ready=%0b required not both 1",
                         a_ready, b_ready);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got %h/%0b required no output",
                             out_data, out_src);
                end else begin
                    logic [WIDTH:0] exp;
                    exp = sb_q.pop_front();
                    if ({out_src, out_data} !== exp) begin
                        errors++;
                        $display("FAIL sb_word: got %h/%0b required %h/%0b",
                                 out_data, out_src, exp[WIDTH-1:0], exp[WIDTH]);
                    end
                end
            end
            if (a_valid && a_ready) sb_q.push_back({1'b0, a_data});
            if (b_valid && b_ready) sb_q.push_back({1'b1, b_data});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached required finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_valid = 1'b1;
        a_data  = 16'h9999;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_src !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: got %0b/%h/%0b required 0/0000/0",
                     out_valid, out_data, out_src);
        end
        checks++;
        if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %0b/%0b required 0/0", a_ready, b_ready);
        end
        a_valid = 1'b0;
    endtask

    task automatic test_single();
        step();
        rst_n     = 1'b1;
        a_valid   = 1'b1;
        a_data    = 16'h1234;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_accept: got a_ready=%0b b_ready=%0b required 1/0",
                     a_ready, b_ready);
        end
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_src !== 1'b0) begin
            errors++;
            $display("FAIL single: got %0b/%h/%0b required 1/1234/0",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_throughput();
        for (int i = 0; i < 8; i++) begin
            step();
            b_valid = 1'b1;
            b_data  = 16'hB000 + 16'(i);
            @(negedge clk);
            checks++;
            if (b_ready !== 1'b1) begin
                errors++;
                $display("FAIL tput_ready[%0d]: got %0b required 1", i, b_ready);
            end
            if (i > 0) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 16'hB000 + 16'(i - 1) ||
                    out_src !== 1'b1) begin
                    errors++;
                    $display("FAIL tput_out[%0d]: got %0b/%h/%0b required 1/%h/1",
                             i, out_valid, out_data, out_src, 16'hB000 + 16'(i - 1));
                end
            end
        end
        step();
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hB007) begin
            errors++;
            $display("FAIL tput_last: got %0b/%h required 1/b007", out_valid, out_data);
        end
    endtask

    task automatic test_contention();
        logic exp_b[4];
`ifdef MUX_ARB_ROUND_ROBIN_EN
        exp_b = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_b = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 4; i++) begin
            step();
            a_valid = 1'b1;
            a_data  = 16'hAAAA;
            b_valid = 1'b1;
            b_data  = 16'h5555;
            @(negedge clk);
            checks++;
            if (a_ready !== !exp_b[i] || b_ready !== exp_b[i]) begin
                errors++;
                $display("FAIL cont_grant[%0d]: got a=%0b b=%0b required a=%0b b=%0b",
                         i, a_ready, b_ready, !exp_b[i], exp_b[i]);
            end
            if (i > 0) begin
                checks++;
                if (out_data !== (exp_b[i-1] ? 16'h5555 : 16'hAAAA) ||
                    out_src !== exp_b[i-1]) begin
                    errors++;
                    $display("FAIL cont_out[%0d]: got %h/%0b required %h/%0b", i,
                             out_data, out_src,
                             exp_b[i-1] ? 16'h5555 : 16'hAAAA, exp_b[i-1]);
                end
            end
        end
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL cont_drain: got valid=%0b q=%0d required 0/0",
                     out_valid, sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        step();
        a_valid   = 1'b1;
        a_data    = 16'h00FF;
        out_ready = 1'b0;
        step();
        a_valid = 1'b0;
        b_valid = 1'b1;
        b_data  = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h00FF || out_src !== 1'b0 ||
                b_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %0b/%h/%0b b_ready=%0b required 1/00ff/0 0",
                         i, out_valid, out_data, out_src, b_ready);
            end
            if (i < 2) step();
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got b_ready=%0b required 1", b_ready);
        end
        step();
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF || out_src !== 1'b1) begin
            errors++;
            $display("FAIL bp_out: got %0b/%h/%0b required 1/beef/1",
                     out_valid, out_data, out_src);
        end
    endtask

    task automatic test_drain();
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL drain: got %0b/%h required 0/beef", out_valid, out_data);
        end
    endtask

    task automatic test_reset_mid();
        step();
        a_valid   = 1'b1;
        a_data    = 16'hCAFE;
        out_ready = 1'b0;
        step();
        a_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hCAFE) begin
            errors++;
            $display("FAIL mid_full: got %0b/%h required 1/cafe", out_valid, out_data);
        end
        #2;
        a_valid   = 1'b1;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_src !== 1'b0 ||
            a_ready !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got %0b/%h/%0b a=%0b b=%0b required 0/0000/0 0 0",
                     out_valid, out_data, out_src, a_ready, b_ready);
        end
        sb_q.delete();
        step();
        rst_n   = 1'b1;
        a_data  = 16'h0A0A;
        b_valid = 1'b1;
        b_data  = 16'h0B0B;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_grant: got a=%0b b=%0b required 1/0",
                     a_ready, b_ready);
        end
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0A0A || out_src !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_out: got %0b/%h/%0b required 1/0a0a/0",
                     out_valid, out_data, out_src);
        end
        step();
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL final_empty: got valid=%0b q=%0d required 0/0",
                     out_valid, sb_q.size());
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        a_valid   = 1'b0;
        a_data    = '0;
        b_valid   = 1'b0;
        b_data    = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_throughput();
        test_contention();
        test_backpressure();
        test_drain();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
